// File: rtl/mini_alu_pkg.sv
// Shared opcode encoding and decode helpers for the mini-ALU pipeline.
`default_nettype none

package mini_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_STO  = 4'd2,
    OP_BLE  = 4'd3,
    OP_JMP  = 4'd4,
    OP_LED  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SMUL = 4'd7,
    OP_MULL = 4'd8,
    OP_HLT  = 4'd9
  } op_e;

  // Ops that update the register file (and therefore may forward).
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_STO, OP_SUB, OP_SMUL, OP_MULL};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mini_alu_regfile.sv
// Register file: two synchronous read ports, one write port.
`default_nettype none

module mini_alu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-during-write returns the old word; the pipeline forwards around it.
  always_ff @(posedge clk) begin
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mini_alu_pipe.sv
// Two-stage (fetch / execute) mini-ALU core with forwarding, branch squash,
// signed multiply, HLT and a wrapping instruction pointer.
`default_nettype none

module mini_alu_pipe
  import mini_alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int IP_W       = 16,
  parameter int LED_W      = 8,
  parameter int SIGNED_CMP = 0,
  localparam int INSTR_W   = OP_W + 3*ADDR_W
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IP_W-1:0]    oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [LED_W-1:0]   oLed,
  output logic               oHalt
);

  localparam int IMM_W = 2*ADDR_W;
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(3*ADDR_W){1'b0}}};

  logic [IP_W-1:0]     ip;
  logic [INSTR_W-1:0]  ex_instr;
  logic                prev_we;
  logic [ADDR_W-1:0]   prev_dst;
  logic [DATA_W-1:0]   prev_result;

  logic [OP_W-1:0]     ex_op;
  logic [ADDR_W-1:0]   ex_dst;
  logic [ADDR_W-1:0]   ex_src1;
  logic [ADDR_W-1:0]   ex_src0;
  logic [DATA_W-1:0]   rdata0;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   s0;
  logic [DATA_W-1:0]   s1;
  logic [2*DATA_W-1:0] s0_ext;
  logic [2*DATA_W-1:0] s1_ext;
  logic [2*DATA_W-1:0] product;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_ext;
  logic [IP_W-1:0]     target;
  logic                ble_le;
  logic                writes;
  logic [DATA_W-1:0]   result;
  logic                taken;
  logic                led_we;
  logic                halt_now;

  assign oIP     = ip;
  assign ex_op   = ex_instr[INSTR_W-1 -: OP_W];
  assign ex_dst  = ex_instr[3*ADDR_W-1 -: ADDR_W];
  assign ex_src1 = ex_instr[2*ADDR_W-1 -: ADDR_W];
  assign ex_src0 = ex_instr[ADDR_W-1:0];

  mini_alu_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (Clock),
    .raddr0 (iInstruction[ADDR_W-1:0]),
    .raddr1 (iInstruction[2*ADDR_W-1 -: ADDR_W]),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .we     (writes),
    .waddr  (ex_dst),
    .wdata  (result)
  );

  // A forward only fires when the previous execute slot really wrote.
  assign s0 = (prev_we && (prev_dst == ex_src0)) ? prev_result : rdata0;
  assign s1 = (prev_we && (prev_dst == ex_src1)) ? prev_result : rdata1;

  assign s0_ext  = {{DATA_W{s0[DATA_W-1]}}, s0};
  assign s1_ext  = {{DATA_W{s1[DATA_W-1]}}, s1};
  assign product = s0_ext * s1_ext;

  assign imm = {ex_src1, ex_src0};

  generate
    if (IMM_W >= DATA_W) begin : g_imm_trunc
      assign imm_ext = imm[DATA_W-1:0];
    end else begin : g_imm_zext
      assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  endgenerate

  generate
    if (ADDR_W >= IP_W) begin : g_tgt_trunc
      assign target = ex_dst[IP_W-1:0];
    end else begin : g_tgt_zext
      assign target = {{(IP_W-ADDR_W){1'b0}}, ex_dst};
    end
  endgenerate

  generate
    if (SIGNED_CMP != 0) begin : g_cmp_signed
      assign ble_le = ($signed(s1) <= $signed(s0));
    end else begin : g_cmp_unsigned
      assign ble_le = (s1 <= s0);
    end
  endgenerate

  assign writes = op_writes(ex_op);

  always_comb begin
    result   = '0;
    taken    = 1'b0;
    led_we   = 1'b0;
    halt_now = 1'b0;
    case (ex_op)
      OP_ADD:  result = s1 + s0;
      OP_SUB:  result = s0 - s1;
      OP_STO:  result = imm_ext;
      OP_SMUL: result = product[2*DATA_W-1 -: DATA_W];
      OP_MULL: result = product[DATA_W-1:0];
      OP_BLE:  taken = ble_le;
      OP_JMP:  taken = 1'b1;
      OP_LED:  led_we = 1'b1;
      OP_HLT:  halt_now = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ip          <= '0;
      ex_instr    <= NOP_INSTR;
      prev_we     <= 1'b0;
      prev_dst    <= '0;
      prev_result <= '0;
      oLed        <= '0;
      oHalt       <= 1'b0;
    end else begin
      prev_we     <= writes;
      prev_dst    <= ex_dst;
      prev_result <= result;
      if (led_we) begin
        oLed <= s1[LED_W-1:0];
      end
      if (halt_now) begin
        oHalt <= 1'b1;
      end
      // Halt freezes IP; a taken branch redirects it. Both squash the fetch.
      if (oHalt || halt_now) begin
        ex_instr <= NOP_INSTR;
      end else if (taken) begin
        ip       <= target;
        ex_instr <= NOP_INSTR;
      end else begin
        ip       <= ip + IP_W'(1);
        ex_instr <= iInstruction;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mini_alu_pipe.sv
// Directed-program bench for mini_alu_pipe with an instruction-level reference
// model checked every cycle, plus literal expectations per program.
`default_nettype none

module tb_mini_alu_pipe;

  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int IW      = 16;
  localparam int LW      = 8;
  localparam int INSTR_W = 4 + 3*AW;

  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADD  = 4'd1;
  localparam logic [3:0] K_STO  = 4'd2;
  localparam logic [3:0] K_BLE  = 4'd3;
  localparam logic [3:0] K_JMP  = 4'd4;
  localparam logic [3:0] K_LED  = 4'd5;
  localparam logic [3:0] K_SUB  = 4'd6;
  localparam logic [3:0] K_SMUL = 4'd7;
  localparam logic [3:0] K_MULL = 4'd8;
  localparam logic [3:0] K_HLT  = 4'd9;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic [IW-1:0]      oIP;
  logic [INSTR_W-1:0] iInstruction;
  logic [LW-1:0]      oLed;
  logic               oHalt;

  logic [3:0]         ip2;
  logic [INSTR_W-1:0] instr2;
  logic [LW-1:0]      led2;
  logic               halt2;

  logic [INSTR_W-1:0] rom [256];

  int vectors = 0;
  int errors  = 0;

  assign iInstruction = rom[oIP[7:0]];
  assign instr2       = '0;

  always #5 Clock = ~Clock;

  mini_alu_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .IP_W(IW), .LED_W(LW), .SIGNED_CMP(0)
  ) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oLed(oLed), .oHalt(oHalt)
  );

  mini_alu_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .IP_W(4), .LED_W(LW), .SIGNED_CMP(0)
  ) dut_wrap (
    .Clock(Clock), .Reset(Reset), .oIP(ip2), .iInstruction(instr2),
    .oLed(led2), .oHalt(halt2)
  );

  // Instruction-level reference: architectural registers, the instruction
  // occupying the execute slot, and the fetch address.
  logic [DW-1:0]      m_regs [256];
  logic [IW-1:0]      m_ip;
  logic [INSTR_W-1:0] m_ex;
  logic [LW-1:0]      m_led;
  logic               m_halt;
  logic [3:0]         m_ip2;

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_regs[i] = '0;
      rom[i]    = '0;
    end
  end

  function automatic logic [INSTR_W-1:0] ins(input logic [3:0] op, input logic [7:0] d,
                                             input logic [7:0] a1, input logic [7:0] a0);
    return {op, d, a1, a0};
  endfunction

  function automatic logic [INSTR_W-1:0] sto(input logic [7:0] d, input logic [15:0] v);
    return {K_STO, d, v[15:8], v[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ip   = '0;
    m_ex   = '0;
    m_led  = '0;
    m_halt = 1'b0;
    m_ip2  = '0;
  endtask

  task automatic model_step();
    logic [3:0]    op;
    logic [7:0]    d, a1, a0;
    logic [DW-1:0] v1, v0;
    longint        p;
    bit            take, hlt;
    op   = m_ex[27:24];
    d    = m_ex[23:16];
    a1   = m_ex[15:8];
    a0   = m_ex[7:0];
    v1   = m_regs[a1];
    v0   = m_regs[a0];
    p    = longint'($signed(v0)) * longint'($signed(v1));
    take = 1'b0;
    hlt  = 1'b0;
    case (op)
      K_ADD:  m_regs[d] = v1 + v0;
      K_SUB:  m_regs[d] = v0 - v1;
      K_STO:  m_regs[d] = {a1, a0};
      K_SMUL: m_regs[d] = p[31:16];
      K_MULL: m_regs[d] = p[15:0];
      K_BLE:  take = (v1 <= v0);
      K_JMP:  take = 1'b1;
      K_LED:  m_led = v1[7:0];
      K_HLT:  hlt = 1'b1;
      default: ;
    endcase
    if (m_halt || hlt) begin
      m_halt = 1'b1;
      m_ex   = '0;
    end else if (take) begin
      m_ip = {8'h00, d};
      m_ex = '0;
    end else begin
      m_ex = rom[m_ip[7:0]];
      m_ip = m_ip + 16'd1;
    end
    m_ip2 = m_ip2 + 4'd1;
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      model_reset();
    end else begin
      check("oIP", 32'(oIP), 32'(m_ip));
      check("oLed", 32'(oLed), 32'(m_led));
      check("oHalt", 32'(oHalt), 32'(m_halt));
      check("oIP_wrap", 32'(ip2), 32'(m_ip2));
    end
    model_step();
  end

  task automatic begin_prog();
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic release_prog();
    @(negedge Clock);
    @(negedge Clock);
    #2 Reset = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 80; i++) begin
      if (oHalt) break;
      @(negedge Clock);
      #1;
    end
    check(name, 32'(oHalt), 32'd1);
  endtask

  task automatic wait_led(input string name, input logic [7:0] exp);
    for (int i = 0; i < 60; i++) begin
      if (oLed == exp) break;
      @(negedge Clock);
      #1;
    end
    check(name, 32'(oLed), 32'(exp));
  endtask

  initial begin
    // Clear the registers the programs use.
    begin_prog();
    for (int r = 0; r < 8; r++) rom[r] = sto(8'(r), 16'h0000);
    rom[8] = ins(K_HLT, 0, 0, 0);
    release_prog();
    wait_halt("init_halt");

    // Forwarding plus SUB ordering.
    begin_prog();
    rom[0] = sto(1, 16'd5);
    rom[1] = sto(2, 16'd7);
    rom[2] = ins(K_ADD, 3, 1, 2);
    rom[3] = ins(K_LED, 0, 3, 0);
    rom[4] = ins(K_SUB, 4, 1, 2);
    rom[5] = ins(K_LED, 0, 4, 0);
    rom[6] = ins(K_HLT, 0, 0, 0);
    release_prog();
    wait_led("fwd_led_12", 8'd12);
    wait_led("sub_led_2", 8'd2);
    wait_halt("fwd_halt");

    // Signed multiply high and low halves.
    begin_prog();
    rom[0] = sto(1, 16'h4000);
    rom[1] = sto(2, 16'hFFFE);
    rom[2] = ins(K_SMUL, 3, 2, 1);
    rom[3] = ins(K_MULL, 4, 2, 1);
    rom[4] = ins(K_LED, 0, 3, 0);
    rom[5] = ins(K_LED, 0, 4, 0);
    rom[6] = ins(K_HLT, 0, 0, 0);
    release_prog();
    wait_led("smul_led_ff", 8'hFF);
    wait_led("mull_led_00", 8'h00);
    wait_halt("mul_halt");

    // Taken BLE and JMP each squash the instruction behind them.
    begin_prog();
    rom[0]  = sto(1, 16'd1);
    rom[1]  = sto(2, 16'd2);
    rom[2]  = ins(K_BLE, 8, 1, 2);
    rom[3]  = sto(5, 16'h0055);
    rom[8]  = ins(K_LED, 0, 5, 0);
    rom[9]  = ins(K_JMP, 12, 0, 0);
    rom[10] = sto(5, 16'h0011);
    rom[12] = ins(K_LED, 0, 5, 0);
    rom[13] = sto(5, 16'h0022);
    rom[14] = ins(K_LED, 0, 5, 0);
    rom[15] = ins(K_HLT, 0, 0, 0);
    release_prog();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      #1;
      if (oIP == 16'd3) break;
    end
    check("ble_at_3", 32'(oIP), 32'd3);
    @(negedge Clock);
    #1;
    check("ble_to_8", 32'(oIP), 32'd8);
    wait_led("jmp_led_22", 8'h22);
    wait_halt("br_halt");

    // Not-taken BLE whose DST matches a later source must not forward.
    begin_prog();
    rom[0] = sto(0, 16'd3);
    rom[1] = sto(1, 16'd9);
    rom[2] = ins(K_BLE, 1, 1, 0);
    rom[3] = ins(K_ADD, 2, 1, 0);
    rom[4] = ins(K_LED, 0, 2, 0);
    rom[5] = ins(K_HLT, 0, 0, 0);
    release_prog();
    wait_halt("stale_halt");
    check("stale_led_12", 32'(oLed), 32'd12);

    // HLT freezes IP and blocks the following store.
    begin_prog();
    rom[0] = sto(6, 16'd0);
    rom[1] = sto(7, 16'h00A5);
    rom[2] = ins(K_LED, 0, 7, 0);
    rom[3] = ins(K_HLT, 0, 0, 0);
    rom[4] = sto(6, 16'd1);
    rom[5] = ins(K_LED, 0, 6, 0);
    release_prog();
    wait_halt("hlt_halt");
    check("hlt_led_a5", 32'(oLed), 32'hA5);
    check("hlt_ip_4", 32'(oIP), 32'd4);
    repeat (5) @(negedge Clock);
    #1;
    check("hlt_ip_frozen", 32'(oIP), 32'd4);
    check("hlt_still_high", 32'(oHalt), 32'd1);

    // Asynchronous reset between edges.
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("areset_ip", 32'(oIP), 32'd0);
    check("areset_led", 32'(oLed), 32'd0);
    check("areset_halt", 32'(oHalt), 32'd0);
    begin_prog();
    rom[0] = ins(K_LED, 0, 6, 0);
    rom[1] = ins(K_HLT, 0, 0, 0);
    release_prog();
    @(posedge Clock);
    #1;
    check("restart_ip_1", 32'(oIP), 32'd1);
    wait_halt("r6_halt");
    check("r6_unchanged", 32'(oLed), 32'd0);

    // 4-bit IP wraps from 15 to 0.
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      #1;
      if (ip2 == 4'd15) break;
    end
    check("wrap_at_15", 32'(ip2), 32'd15);
    @(negedge Clock);
    #1;
    check("wrap_to_0", 32'(ip2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
